fc_relu_ctrl: RTL and testbench



---
 rtl/fc_relu_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fc_relu_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_relu_ctrl.sv
// rtl/fc_relu_ctrl.sv - FC layer sequencer with threshold-ReLU and 2-entry output queue (optional FC_RELU_ZCNT_EN)
module fc_relu_ctrl #(
    parameter int BITWIDTH = 8,
    parameter int LENGTH   = 4,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [CNT_W-1:0]             num_vec,
    input  logic [BITWIDTH-1:0]          threshold,
    output logic                         busy,
    output logic                         done,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BITWIDTH*LENGTH-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BITWIDTH*LENGTH-1:0]   out_data,
    output logic                         out_last
`ifdef FC_RELU_ZCNT_EN
    ,
    output logic [CNT_W+$clog2(LENGTH)-1:0] zero_cnt
`endif
);

    localparam int W = BITWIDTH * LENGTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                      state;
    logic [CNT_W-1:0]            num_vec_q;
    logic [CNT_W-1:0]            acc_cnt;
    logic [CNT_W-1:0]            acc_next;
    logic signed [BITWIDTH-1:0]  thr_q;
    logic signed [BITWIDTH-1:0]  thr_eff;
    logic                        done_q;

    logic [W-1:0]                q_data [2];
    logic                        q_last [2];
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [1:0]                  occ;

    logic                        push;
    logic                        pop;
    logic                        last_push;
    logic [W-1:0]                act;

    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign in_ready  = (state == S_RUN) && (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign out_data  = out_valid ? q_data[rd_ptr] : '0;
    assign out_last  = out_valid & q_last[rd_ptr];

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign acc_next  = acc_cnt + 1'b1;
    assign last_push = (acc_next == num_vec_q);
    // Negative thresholds clamp to zero so the output is always non-negative.
    assign thr_eff   = thr_q[BITWIDTH-1] ? '0 : thr_q;

`ifdef FC_RELU_ZCNT_EN
    localparam int ZW  = CNT_W + $clog2(LENGTH);
    localparam int ZCW = $clog2(LENGTH + 1);
    logic [ZCW-1:0] zero_hits;
    logic [ZW:0]    zero_sum;
`endif

    always_comb begin
        logic signed [BITWIDTH-1:0] lane;
        act = '0;
`ifdef FC_RELU_ZCNT_EN
        zero_hits = '0;
`endif
        for (int i = 0; i < LENGTH; i++) begin
            lane = in_data[i*BITWIDTH +: BITWIDTH];
            if (lane > thr_eff) begin
                act[i*BITWIDTH +: BITWIDTH] = in_data[i*BITWIDTH +: BITWIDTH];
            end
`ifdef FC_RELU_ZCNT_EN
            else begin
                zero_hits = zero_hits + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            num_vec_q <= '0;
            acc_cnt   <= '0;
            thr_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_vec != '0) begin
                            num_vec_q <= num_vec;
                            thr_q     <= threshold;
                            acc_cnt   <= '0;
                            state     <= S_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (push) begin
                        acc_cnt <= acc_next;
                        if (last_push) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && out_last) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                q_data[i] <= '0;
                q_last[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                q_data[wr_ptr] <= act;
                q_last[wr_ptr] <= last_push;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FC_RELU_ZCNT_EN
    assign zero_sum = {1'b0, zero_cnt} + (ZW+1)'(zero_hits);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            zero_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            zero_cnt <= '0;
        end else if (push) begin
            zero_cnt <= zero_sum[ZW] ? '1 : zero_sum[ZW-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_fc_relu_ctrl.sv
// tb/tb_fc_relu_ctrl.sv - directed self-checking bench for fc_relu_ctrl
module tb_fc_relu_ctrl;
    localparam int B = 8;
    localparam int L = 4;
    localparam int C = 16;
    localparam int W = B * L;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [C-1:0]  num_vec;
    logic [B-1:0]  threshold;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
`ifdef FC_RELU_ZCNT_EN
    logic [C+$clog2(L)-1:0] zero_cnt;
`endif

    fc_relu_ctrl #(.BITWIDTH(B), .LENGTH(L), .CNT_W(C)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .num_vec   (num_vec),
        .threshold (threshold),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef FC_RELU_ZCNT_EN
        ,
        .zero_cnt  (zero_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    logic [W:0] obs[$];

    // Output handshakes and done pulses, observed mid-cycle.
    always @(negedge clk) begin
        if (out_valid && out_ready) obs.push_back({out_last, out_data});
        if (done) done_seen++;
    end

    function automatic logic [W-1:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input int n, input int thr);
        start = 1'b1;
        num_vec = n[C-1:0];
        threshold = thr[B-1:0];
        step();
        start = 1'b0;
    endtask

    task automatic send_one(input logic [W-1:0] v);
        bit ok = 0;
        bit hs;
        in_valid = 1'b1;
        in_data = v;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            hs = in_ready;
            step();
            if (hs) ok = 1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: accepted=%0b required=1", ok);
        end
    endtask

    task automatic wait_done(output int cyc);
        bit got = 0;
        cyc = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            cyc++;
            if (done) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL done_timeout: done=%0b required=1", done);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_at_done: busy=%0b required=0", busy);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 0; num_vec = 0; threshold = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        step(); step();
        n_checks++;
        if ({busy, done, in_ready, out_valid, out_last} !== 5'b0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%0b done=%0b in_ready=%0b out_valid=%0b out_last=%0b out_data=%h required all 0",
                     busy, done, in_ready, out_valid, out_last, out_data);
        end
        rstn = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: in_ready=%0b busy=%0b required 0 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_v[3];
        int cyc;
        int base;
        exp_v[0] = pk(5, 0, 0, 127);
        exp_v[1] = pk(0, 1, 2, 0);
        exp_v[2] = pk(10, 10, 10, 10);
        out_ready = 1'b1;
        obs.delete();
        start_layer(3, 0);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL enter_run: busy=%0b in_ready=%0b required 1 1", busy, in_ready);
        end
        send_one(pk(5, -3, 0, 127));
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_v[0] || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_v0: valid=%0b data=%h last=%0b required 1 %h 0", out_valid, out_data, out_last, exp_v[0]);
        end
        send_one(pk(-128, 1, 2, -1));
        n_checks++;
        if (out_data !== exp_v[1] || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_v1: data=%h last=%0b required %h 0", out_data, out_last, exp_v[1]);
        end
        send_one(pk(10, 10, 10, 10));
        n_checks++;
        if (out_data !== exp_v[2] || out_last !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_v2: data=%h last=%0b in_ready=%0b required %h 1 0", out_data, out_last, in_ready, exp_v[2]);
        end
        base = done_seen;
        wait_done(cyc);
        n_checks++;
        if (cyc !== 1) begin
            n_fail++;
            $display("FAIL done_latency: cycles=%0d required 1", cyc);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || done_seen !== base + 1) begin
            n_fail++;
            $display("FAIL done_pulse: done=%0b pulses=%0d required 0 %0d", done, done_seen - base, 1);
        end
        n_checks++;
        if (obs.size() !== 3) begin
            n_fail++;
            $display("FAIL basic_count: got=%0d required 3", obs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== {(i == 2) ? 1'b1 : 1'b0, exp_v[i]}) begin
                    n_fail++;
                    $display("FAIL basic_stream[%0d]: got=%h required=%h", i, obs[i], {(i == 2) ? 1'b1 : 1'b0, exp_v[i]});
                end
            end
        end
    endtask

    task automatic test_threshold();
        int cyc;
        logic [W:0] e;
        out_ready = 1'b1;
        obs.delete();
        start_layer(1, 10);
        send_one(pk(10, 11, -20, 100));
        wait_done(cyc);
        e = {1'b1, pk(0, 11, 0, 100)};
        n_checks++;
        if (obs.size() !== 1 || obs[0] !== e) begin
            n_fail++;
            $display("FAIL thr_pos: got=%h n=%0d required=%h", (obs.size() > 0) ? obs[0] : '0, obs.size(), e);
        end
        obs.delete();
        step();
        start_layer(1, -5);
        send_one(pk(-1, 3, 0, -128));
        wait_done(cyc);
        e = {1'b1, pk(0, 3, 0, 0)};
        n_checks++;
        if (obs.size() !== 1 || obs[0] !== e) begin
            n_fail++;
            $display("FAIL thr_neg: got=%h n=%0d required=%h", (obs.size() > 0) ? obs[0] : '0, obs.size(), e);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] vin[4];
        logic [W-1:0] ev[4];
        int idx = 0;
        int cyc;
        bit hs;
        vin[0] = pk(1, 2, 3, 4);      ev[0] = pk(1, 2, 3, 4);
        vin[1] = pk(-1, -2, 5, 6);    ev[1] = pk(0, 0, 5, 6);
        vin[2] = pk(7, -8, 9, -10);   ev[2] = pk(7, 0, 9, 0);
        vin[3] = pk(100, 0, -100, 50); ev[3] = pk(100, 0, 0, 50);
        out_ready = 1'b0;
        obs.delete();
        start_layer(4, 0);
        in_valid = 1'b1;
        in_data = vin[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hs = in_ready;
            step();
            if (hs) begin
                idx++;
                in_data = vin[idx];
            end
        end
        n_checks++;
        if (idx !== 2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: accepted=%0d in_ready=%0b required 2 0", idx, in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== ev[0]) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%0b data=%h required 1 %h", out_valid, out_data, ev[0]);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && idx < 4; i++) begin
            @(negedge clk);
            hs = in_ready;
            step();
            if (hs) begin
                idx++;
                if (idx < 4) in_data = vin[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (obs.size() !== 4) begin
            n_fail++;
            $display("FAIL bp_count: got=%0d required 4", obs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (obs[i] !== {(i == 3) ? 1'b1 : 1'b0, ev[i]}) begin
                    n_fail++;
                    $display("FAIL bp_stream[%0d]: got=%h required=%h", i, obs[i], {(i == 3) ? 1'b1 : 1'b0, ev[i]});
                end
            end
        end
        step();
    endtask

    task automatic test_zero_layer();
        start = 1'b1;
        num_vec = '0;
        threshold = '0;
        step();
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_layer: done=%0b busy=%0b in_ready=%0b required 1 0 0", done, busy, in_ready);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_layer_after: done=%0b busy=%0b required 0 0", done, busy);
        end
    endtask

    task automatic test_start_during_run();
        int cyc;
        logic [W:0] e0;
        logic [W:0] e1;
        out_ready = 1'b1;
        obs.delete();
        start_layer(2, 0);
        start = 1'b1;
        num_vec = 16'd5;
        threshold = 8'd50;
        step();
        start = 1'b0;
        send_one(pk(60, 20, -1, 49));
        send_one(pk(51, 50, 1, 0));
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_len: in_ready=%0b busy=%0b required 0 1", in_ready, busy);
        end
        wait_done(cyc);
        e0 = {1'b0, pk(60, 20, 0, 49)};
        e1 = {1'b1, pk(51, 50, 1, 0)};
        n_checks++;
        if (obs.size() !== 2 || obs[0] !== e0 || obs[1] !== e1) begin
            n_fail++;
            $display("FAIL restart_data: n=%0d first=%h required 2 %h %h", obs.size(), (obs.size() > 0) ? obs[0] : '0, e0, e1);
        end
        step();
    endtask

    task automatic test_reset_mid_layer();
        int base;
        int cyc;
        logic [W:0] e;
        out_ready = 1'b0;
        obs.delete();
        start_layer(5, 0);
        send_one(pk(1, 1, 1, 1));
        send_one(pk(2, 2, 2, 2));
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_full: in_ready=%0b out_valid=%0b required 0 1", in_ready, out_valid);
        end
        base = done_seen;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: out_valid=%0b busy=%0b in_ready=%0b data=%h required 0 0 0 0",
                     out_valid, busy, in_ready, out_data);
        end
        step(); step();
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (done_seen !== base || obs.size() !== 0) begin
            n_fail++;
            $display("FAIL mid_no_done: pulses=%0d outputs=%0d required 0 0", done_seen - base, obs.size());
        end
        start_layer(1, 0);
        send_one(pk(-7, 8, 9, -1));
        wait_done(cyc);
        e = {1'b1, pk(0, 8, 9, 0)};
        n_checks++;
        if (obs.size() !== 1 || obs[0] !== e) begin
            n_fail++;
            $display("FAIL fresh_layer: n=%0d got=%h required=%h", obs.size(), (obs.size() > 0) ? obs[0] : '0, e);
        end
        step();
    endtask

`ifdef FC_RELU_ZCNT_EN
    task automatic test_zero_cnt();
        int cyc;
        out_ready = 1'b1;
        start_layer(2, 0);
        send_one(pk(0, -1, 5, 6));
        send_one(pk(-2, -3, -4, 1));
        wait_done(cyc);
        step();
        n_checks++;
        if (zero_cnt !== 18'd5) begin
            n_fail++;
            $display("FAIL zero_cnt: got=%0d required 5", zero_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_backpressure();
        test_zero_layer();
        test_start_during_run();
        test_reset_mid_layer();
`ifdef FC_RELU_ZCNT_EN
        test_zero_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end
endmodule
